// File: rtl/bidi_message_queue_fifo_if.sv
// ---------------------------------------------------------------------------
// bidi_message_queue_fifo_if
//
// Bundles every signal of the bidirectional message queue except clk/rst_n.
//
// Signal groups:
//   in_wr_*   host -> queue   (inbound push side)
//   in_rd_*   queue -> device (inbound pop side)
//   out_wr_*  device -> queue (outbound push side)
//   out_rd_*  queue -> host   (outbound pop side)
//   in_flush / out_flush      per-channel synchronous clear
//   in_count / out_count      channel occupancy, 0..DEPTH
//   out_irq                   registered outbound level interrupt
//
// Handshake semantics (all four valid/ready pairs):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   A sender may not withdraw or change its data while valid=1 and ready=0.
//   ready and valid driven by the queue come only from registered state
//   (plus rst_n forcing wr_ready low), so there is no combinational path
//   from an incoming valid or ready to any outgoing handshake signal.
//
// Modports:
//   master - the surrounding system (host + device) driving the queue.
//   slave  - the queue itself.
// ---------------------------------------------------------------------------
interface bidi_message_queue_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // inbound channel: host -> device
  logic                  in_wr_valid;
  logic                  in_wr_ready;
  logic [DATA_WIDTH-1:0] in_wr_data;
  logic                  in_rd_valid;
  logic                  in_rd_ready;
  logic [DATA_WIDTH-1:0] in_rd_data;

  // outbound channel: device -> host
  logic                  out_wr_valid;
  logic                  out_wr_ready;
  logic [DATA_WIDTH-1:0] out_wr_data;
  logic                  out_rd_valid;
  logic                  out_rd_ready;
  logic [DATA_WIDTH-1:0] out_rd_data;

  // control and status
  logic                  in_flush;
  logic                  out_flush;
  logic [CNT_W-1:0]      in_count;
  logic [CNT_W-1:0]      out_count;
  logic                  out_irq;

  modport master (
    output in_wr_valid,  in_wr_data,  input  in_wr_ready,
    input  in_rd_valid,  in_rd_data,  output in_rd_ready,
    output out_wr_valid, out_wr_data, input  out_wr_ready,
    input  out_rd_valid, out_rd_data, output out_rd_ready,
    output in_flush,     out_flush,
    input  in_count,     out_count,   out_irq
  );

  modport slave (
    input  in_wr_valid,  in_wr_data,  output in_wr_ready,
    output in_rd_valid,  in_rd_data,  input  in_rd_ready,
    input  out_wr_valid, out_wr_data, output out_wr_ready,
    output out_rd_valid, out_rd_data, input  out_rd_ready,
    input  in_flush,     out_flush,
    output in_count,     out_count,   out_irq
  );
endinterface

// File: rtl/bidi_message_queue_fifo.sv
// ---------------------------------------------------------------------------
// bidi_message_queue_fifo
//
// Two independent circular-buffer FIFOs sharing one clock:
//   channel 0 (inbound)  : host pushes on in_wr_*,  device pops on in_rd_*
//   channel 1 (outbound) : device pushes on out_wr_*, host pops on out_rd_*
//
// Ports:
//   clk    - single rising-edge clock
//   rst_n  - synchronous active-low reset; clears pointers, counts, out_irq
//   bus    - bidi_message_queue_fifo_if.slave, all handshake/status signals
//
// Parameters:
//   DATA_WIDTH     - message word width (>=1)
//   DEPTH          - entries per channel, power of two, >=2
//   OUT_IRQ_THRESH - out_irq is 1 while out_count >= this value (1..DEPTH)
//
// Pointers carry one extra wrap bit so full (MSBs differ, low bits equal)
// and empty (pointers equal) are distinguishable without using the count.
// The count is kept as its own register so it is directly observable and
// can be cross-checked against the pointers.
// ---------------------------------------------------------------------------
module bidi_message_queue_fifo #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 4,
  parameter int OUT_IRQ_THRESH = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  bidi_message_queue_fifo_if.slave  bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int NCH   = 2;
  localparam int CH_IN  = 0;
  localparam int CH_OUT = 1;
  localparam logic [CNT_W-1:0] IRQ_THRESH = CNT_W'(OUT_IRQ_THRESH);

  // -------------------------------------------------------------------------
  // Per-channel views of the interface (index 0 inbound, 1 outbound)
  // -------------------------------------------------------------------------
  logic [NCH-1:0]        wr_valid;
  logic [NCH-1:0]        wr_ready;
  logic [NCH-1:0]        rd_valid;
  logic [NCH-1:0]        rd_ready;
  logic [NCH-1:0]        flush;
  logic [NCH-1:0]        full;
  logic [NCH-1:0]        empty;
  logic [NCH-1:0]        push;
  logic [NCH-1:0]        pop;
  logic [DATA_WIDTH-1:0] wr_data [NCH];
  logic [DATA_WIDTH-1:0] rd_data [NCH];

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PTR_W-1:0]      wr_ptr_q [NCH];
  logic [PTR_W-1:0]      wr_ptr_d [NCH];
  logic [PTR_W-1:0]      rd_ptr_q [NCH];
  logic [PTR_W-1:0]      rd_ptr_d [NCH];
  logic [CNT_W-1:0]      count_q  [NCH];
  logic [CNT_W-1:0]      count_d  [NCH];
  logic [DATA_WIDTH-1:0] mem_q    [NCH][DEPTH];
  logic [DATA_WIDTH-1:0] mem_d    [NCH][DEPTH];
  logic                  irq_q;
  logic                  irq_d;

  // -------------------------------------------------------------------------
  // Interface to channel-array mapping
  // -------------------------------------------------------------------------
  assign wr_valid[CH_IN]  = bus.in_wr_valid;
  assign wr_valid[CH_OUT] = bus.out_wr_valid;
  assign rd_ready[CH_IN]  = bus.in_rd_ready;
  assign rd_ready[CH_OUT] = bus.out_rd_ready;
  assign flush[CH_IN]     = bus.in_flush;
  assign flush[CH_OUT]    = bus.out_flush;
  assign wr_data[CH_IN]   = bus.in_wr_data;
  assign wr_data[CH_OUT]  = bus.out_wr_data;

  assign bus.in_wr_ready  = wr_ready[CH_IN];
  assign bus.out_wr_ready = wr_ready[CH_OUT];
  assign bus.in_rd_valid  = rd_valid[CH_IN];
  assign bus.out_rd_valid = rd_valid[CH_OUT];
  assign bus.in_rd_data   = rd_data[CH_IN];
  assign bus.out_rd_data  = rd_data[CH_OUT];
  assign bus.in_count     = count_q[CH_IN];
  assign bus.out_count    = count_q[CH_OUT];
  assign bus.out_irq      = irq_q;

  // -------------------------------------------------------------------------
  // Status and handshake outputs, derived from registered state only.
  // wr_ready is additionally gated by rst_n so no word can be offered an
  // accepting handshake while the block is being reset.
  // -------------------------------------------------------------------------
  always_comb begin
    full     = '0;
    empty    = '0;
    wr_ready = '0;
    rd_valid = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      rd_data[ch] = '0;
    end
    for (int ch = 0; ch < NCH; ch++) begin
      empty[ch]    = (wr_ptr_q[ch] == rd_ptr_q[ch]);
      full[ch]     = (wr_ptr_q[ch][PTR_W-1] != rd_ptr_q[ch][PTR_W-1]) &&
                     (wr_ptr_q[ch][AW-1:0] == rd_ptr_q[ch][AW-1:0]);
      wr_ready[ch] = rst_n && !full[ch];
      rd_valid[ch] = !empty[ch];
      // Head word only while valid; zero otherwise so stale entries never leak.
      if (rd_valid[ch]) begin
        rd_data[ch] = mem_q[ch][rd_ptr_q[ch][AW-1:0]];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic for both channels plus the outbound interrupt
  // -------------------------------------------------------------------------
  always_comb begin
    push     = '0;
    pop      = '0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    irq_d    = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      push[ch] = wr_valid[ch] && wr_ready[ch];
      pop[ch]  = rd_valid[ch] && rd_ready[ch];
      if (flush[ch]) begin
        // Flush wins: any handshake seen this cycle is dropped on the floor.
        wr_ptr_d[ch] = '0;
        rd_ptr_d[ch] = '0;
        count_d[ch]  = '0;
      end else begin
        if (push[ch]) begin
          mem_d[ch][wr_ptr_q[ch][AW-1:0]] = wr_data[ch];
          wr_ptr_d[ch] = wr_ptr_q[ch] + PTR_W'(1);
        end
        if (pop[ch]) begin
          rd_ptr_d[ch] = rd_ptr_q[ch] + PTR_W'(1);
        end
        // push is impossible when full and pop impossible when empty,
        // so this stays within 0..DEPTH without saturation logic.
        count_d[ch] = count_q[ch] + CNT_W'(push[ch]) - CNT_W'(pop[ch]);
      end
    end
    // Computed from the next count so the flop lines up with out_count.
    irq_d = (count_d[CH_OUT] >= IRQ_THRESH);
  end

  // -------------------------------------------------------------------------
  // Control registers with synchronous reset
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int ch = 0; ch < NCH; ch++) begin
        wr_ptr_q[ch] <= '0;
        rd_ptr_q[ch] <= '0;
        count_q[ch]  <= '0;
      end
      irq_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
    end
  end

  // Storage needs no reset: entries are only visible between a push and
  // the matching pop, and rd_data is zeroed while a channel is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_bidi_message_queue_fifo.sv
module tb_bidi_message_queue_fifo;
  localparam int DW     = 32;
  localparam int DEPTH  = 4;
  localparam int THRESH = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bidi_message_queue_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  bidi_message_queue_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .OUT_IRQ_THRESH(THRESH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_in_q[$];
  logic [DW-1:0] exp_out_q[$];
  logic [DW-1:0] exp_w;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_wr_valid  = 1'b0;
    bus.in_wr_data   = '0;
    bus.in_rd_ready  = 1'b0;
    bus.out_wr_valid = 1'b0;
    bus.out_wr_data  = '0;
    bus.out_rd_ready = 1'b0;
    bus.in_flush     = 1'b0;
    bus.out_flush    = 1'b0;
  endtask

  task automatic drive_in(input logic [DW-1:0] d);
    bus.in_wr_valid = 1'b1;
    bus.in_wr_data  = d;
    exp_in_q.push_back(d);
    step();
    bus.in_wr_valid = 1'b0;
  endtask

  task automatic drive_out(input logic [DW-1:0] d);
    bus.out_wr_valid = 1'b1;
    bus.out_wr_data  = d;
    exp_out_q.push_back(d);
    step();
    bus.out_wr_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    n_checks++; if (bus.in_wr_ready !== 1'b0) begin $display("FAIL reset_in_wr_ready: got %b want 0", bus.in_wr_ready); n_fail++; end
    n_checks++; if (bus.out_wr_ready !== 1'b0) begin $display("FAIL reset_out_wr_ready: got %b want 0", bus.out_wr_ready); n_fail++; end
    n_checks++; if (bus.in_rd_valid !== 1'b0) begin $display("FAIL reset_in_rd_valid: got %b want 0", bus.in_rd_valid); n_fail++; end
    n_checks++; if (bus.out_rd_valid !== 1'b0) begin $display("FAIL reset_out_rd_valid: got %b want 0", bus.out_rd_valid); n_fail++; end
    n_checks++; if (bus.in_count !== CNT_W'(0)) begin $display("FAIL reset_in_count: got %0d want 0", bus.in_count); n_fail++; end
    n_checks++; if (bus.out_count !== CNT_W'(0)) begin $display("FAIL reset_out_count: got %0d want 0", bus.out_count); n_fail++; end
    n_checks++; if (bus.out_irq !== 1'b0) begin $display("FAIL reset_out_irq: got %b want 0", bus.out_irq); n_fail++; end
    n_checks++; if (bus.in_rd_data !== '0) begin $display("FAIL reset_in_rd_data: got %h want 0", bus.in_rd_data); n_fail++; end
    n_checks++; if (bus.out_rd_data !== '0) begin $display("FAIL reset_out_rd_data: got %h want 0", bus.out_rd_data); n_fail++; end
    rst_n = 1'b1;
    step();
    n_checks++; if (bus.in_wr_ready !== 1'b1) begin $display("FAIL release_in_wr_ready: got %b want 1", bus.in_wr_ready); n_fail++; end
    n_checks++; if (bus.out_wr_ready !== 1'b1) begin $display("FAIL release_out_wr_ready: got %b want 1", bus.out_wr_ready); n_fail++; end
    n_checks++; if (bus.in_rd_valid !== 1'b0) begin $display("FAIL release_in_rd_valid: got %b want 0", bus.in_rd_valid); n_fail++; end
  endtask

  task automatic test_fill_drain();
    bus.in_rd_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_in(DW'(32'h11 * (i + 1)));
      n_checks++; if (bus.in_count !== CNT_W'(i + 1)) begin $display("FAIL fill_count_%0d: got %0d want %0d", i, bus.in_count, i + 1); n_fail++; end
    end
    n_checks++; if (bus.in_wr_ready !== 1'b0) begin $display("FAIL fill_full_ready: got %b want 0", bus.in_wr_ready); n_fail++; end
    // 0x55 is offered while full and must be refused
    bus.in_wr_valid = 1'b1;
    bus.in_wr_data  = 32'h55;
    step();
    bus.in_wr_valid = 1'b0;
    n_checks++; if (bus.in_count !== CNT_W'(DEPTH)) begin $display("FAIL fill_overflow_count: got %0d want %0d", bus.in_count, DEPTH); n_fail++; end
    bus.in_rd_ready = 1'b1;
    while (exp_in_q.size() > 0) begin
      exp_w = exp_in_q.pop_front();
      n_checks++; if (bus.in_rd_valid !== 1'b1 || bus.in_rd_data !== exp_w) begin $display("FAIL drain_data: got v=%b d=%h want v=1 d=%h", bus.in_rd_valid, bus.in_rd_data, exp_w); n_fail++; end
      step();
    end
    bus.in_rd_ready = 1'b0;
    n_checks++; if (bus.in_rd_valid !== 1'b0 || bus.in_rd_data !== '0) begin $display("FAIL drain_empty: got v=%b d=%h want v=0 d=0", bus.in_rd_valid, bus.in_rd_data); n_fail++; end
    n_checks++; if (bus.in_count !== CNT_W'(0)) begin $display("FAIL drain_count: got %0d want 0", bus.in_count); n_fail++; end
  endtask

  task automatic test_streaming();
    bus.in_wr_valid = 1'b1;
    bus.in_rd_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.in_wr_data = DW'(k);
      exp_in_q.push_back(DW'(k));
      if (k == 0) begin
        n_checks++; if (bus.in_rd_valid !== 1'b0) begin $display("FAIL stream_first_valid: got %b want 0", bus.in_rd_valid); n_fail++; end
      end else begin
        exp_w = exp_in_q.pop_front();
        n_checks++; if (bus.in_rd_valid !== 1'b1 || bus.in_rd_data !== exp_w) begin $display("FAIL stream_data_%0d: got v=%b d=%h want v=1 d=%h", k, bus.in_rd_valid, bus.in_rd_data, exp_w); n_fail++; end
      end
      step();
      n_checks++; if (bus.in_count !== CNT_W'(1)) begin $display("FAIL stream_count_%0d: got %0d want 1", k, bus.in_count); n_fail++; end
    end
    bus.in_wr_valid = 1'b0;
    exp_w = exp_in_q.pop_front();
    n_checks++; if (bus.in_rd_valid !== 1'b1 || bus.in_rd_data !== exp_w) begin $display("FAIL stream_last: got v=%b d=%h want v=1 d=%h", bus.in_rd_valid, bus.in_rd_data, exp_w); n_fail++; end
    step();
    bus.in_rd_ready = 1'b0;
    n_checks++; if (bus.in_count !== CNT_W'(0) || bus.in_rd_valid !== 1'b0) begin $display("FAIL stream_end: got cnt=%0d v=%b want cnt=0 v=0", bus.in_count, bus.in_rd_valid); n_fail++; end
  endtask

  task automatic test_full_simul();
    bus.out_rd_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive_out(DW'(32'hB0 + i));
    end
    n_checks++; if (bus.out_count !== CNT_W'(DEPTH) || bus.out_wr_ready !== 1'b0) begin $display("FAIL fullsim_fill: got cnt=%0d rdy=%b want cnt=%0d rdy=0", bus.out_count, bus.out_wr_ready, DEPTH); n_fail++; end
    n_checks++; if (bus.out_irq !== 1'b1) begin $display("FAIL fullsim_irq: got %b want 1", bus.out_irq); n_fail++; end
    bus.out_wr_valid = 1'b1;
    bus.out_wr_data  = 32'hAA;
    bus.out_rd_ready = 1'b1;
    exp_w = exp_out_q.pop_front();
    n_checks++; if (bus.out_rd_data !== exp_w) begin $display("FAIL fullsim_head: got %h want %h", bus.out_rd_data, exp_w); n_fail++; end
    step();
    n_checks++; if (bus.out_count !== CNT_W'(DEPTH - 1) || bus.out_wr_ready !== 1'b1) begin $display("FAIL fullsim_pop_only: got cnt=%0d rdy=%b want cnt=%0d rdy=1", bus.out_count, bus.out_wr_ready, DEPTH - 1); n_fail++; end
    bus.out_rd_ready = 1'b0;
    exp_out_q.push_back(32'hAA);
    step();
    bus.out_wr_valid = 1'b0;
    n_checks++; if (bus.out_count !== CNT_W'(DEPTH)) begin $display("FAIL fullsim_accept_aa: got %0d want %0d", bus.out_count, DEPTH); n_fail++; end
    bus.out_rd_ready = 1'b1;
    while (exp_out_q.size() > 0) begin
      exp_w = exp_out_q.pop_front();
      n_checks++; if (bus.out_rd_valid !== 1'b1 || bus.out_rd_data !== exp_w) begin $display("FAIL fullsim_drain: got v=%b d=%h want v=1 d=%h", bus.out_rd_valid, bus.out_rd_data, exp_w); n_fail++; end
      step();
    end
    bus.out_rd_ready = 1'b0;
    n_checks++; if (bus.out_count !== CNT_W'(0) || bus.out_irq !== 1'b0) begin $display("FAIL fullsim_end: got cnt=%0d irq=%b want 0 0", bus.out_count, bus.out_irq); n_fail++; end
  endtask

  task automatic test_irq();
    drive_out(32'hA0);
    n_checks++; if (bus.out_count !== CNT_W'(1) || bus.out_irq !== 1'b0) begin $display("FAIL irq_one: got cnt=%0d irq=%b want 1 0", bus.out_count, bus.out_irq); n_fail++; end
    drive_out(32'hA1);
    n_checks++; if (bus.out_count !== CNT_W'(2) || bus.out_irq !== 1'b1) begin $display("FAIL irq_two: got cnt=%0d irq=%b want 2 1", bus.out_count, bus.out_irq); n_fail++; end
    bus.out_rd_ready = 1'b1;
    exp_w = exp_out_q.pop_front();
    n_checks++; if (bus.out_rd_data !== exp_w) begin $display("FAIL irq_pop_data: got %h want %h", bus.out_rd_data, exp_w); n_fail++; end
    step();
    bus.out_rd_ready = 1'b0;
    n_checks++; if (bus.out_count !== CNT_W'(1) || bus.out_irq !== 1'b0) begin $display("FAIL irq_after_pop: got cnt=%0d irq=%b want 1 0", bus.out_count, bus.out_irq); n_fail++; end
    bus.out_rd_ready = 1'b1;
    exp_w = exp_out_q.pop_front();
    n_checks++; if (bus.out_rd_data !== exp_w) begin $display("FAIL irq_pop2_data: got %h want %h", bus.out_rd_data, exp_w); n_fail++; end
    step();
    bus.out_rd_ready = 1'b0;
  endtask

  task automatic test_flush();
    drive_in(32'h61);
    drive_in(32'h62);
    drive_in(32'h63);
    drive_out(32'hC0);
    drive_out(32'hC1);
    n_checks++; if (bus.in_count !== CNT_W'(3)) begin $display("FAIL flush_pre_count: got %0d want 3", bus.in_count); n_fail++; end
    bus.in_flush    = 1'b1;
    bus.in_wr_valid = 1'b1;
    bus.in_wr_data  = 32'h77;
    step();
    bus.in_flush    = 1'b0;
    bus.in_wr_valid = 1'b0;
    exp_in_q.delete();
    n_checks++; if (bus.in_count !== CNT_W'(0) || bus.in_rd_valid !== 1'b0 || bus.in_rd_data !== '0) begin $display("FAIL flush_in: got cnt=%0d v=%b d=%h want 0 0 0", bus.in_count, bus.in_rd_valid, bus.in_rd_data); n_fail++; end
    n_checks++; if (bus.out_count !== CNT_W'(2) || bus.out_irq !== 1'b1) begin $display("FAIL flush_out_intact: got cnt=%0d irq=%b want 2 1", bus.out_count, bus.out_irq); n_fail++; end
    // fresh data after flush must come out first
    drive_in(32'h78);
    exp_w = exp_in_q[0];
    n_checks++; if (bus.in_rd_data !== exp_w) begin $display("FAIL flush_refill: got %h want %h", bus.in_rd_data, exp_w); n_fail++; end
    for (int i = 0; i < DEPTH - 1; i++) drive_in(DW'(32'h79 + i));
    n_checks++; if (bus.in_wr_ready !== 1'b0) begin $display("FAIL flush_full_ready: got %b want 0", bus.in_wr_ready); n_fail++; end
    bus.in_flush = 1'b1;
    step();
    bus.in_flush = 1'b0;
    exp_in_q.delete();
    n_checks++; if (bus.in_wr_ready !== 1'b1 || bus.in_count !== CNT_W'(0)) begin $display("FAIL flush_full_recover: got rdy=%b cnt=%0d want 1 0", bus.in_wr_ready, bus.in_count); n_fail++; end
    bus.out_rd_ready = 1'b1;
    exp_w = exp_out_q.pop_front();
    n_checks++; if (bus.out_rd_data !== exp_w) begin $display("FAIL flush_out_head: got %h want %h", bus.out_rd_data, exp_w); n_fail++; end
    step();
    bus.out_flush = 1'b1;
    step();
    bus.out_flush    = 1'b0;
    bus.out_rd_ready = 1'b0;
    exp_out_q.delete();
    n_checks++; if (bus.out_count !== CNT_W'(0) || bus.out_rd_valid !== 1'b0 || bus.out_irq !== 1'b0) begin $display("FAIL flush_out: got cnt=%0d v=%b irq=%b want 0 0 0", bus.out_count, bus.out_rd_valid, bus.out_irq); n_fail++; end
  endtask

  task automatic test_reset_mid();
    drive_in(32'h81);
    drive_in(32'h82);
    drive_in(32'h83);
    drive_out(32'hD0);
    drive_out(32'hD1);
    rst_n = 1'b0;
    bus.in_wr_valid = 1'b1;
    bus.in_wr_data  = 32'h99;
    #1;
    n_checks++; if (bus.in_wr_ready !== 1'b0 || bus.out_wr_ready !== 1'b0) begin $display("FAIL rstmid_ready: got in=%b out=%b want 0 0", bus.in_wr_ready, bus.out_wr_ready); n_fail++; end
    step();
    bus.in_wr_valid = 1'b0;
    exp_in_q.delete();
    exp_out_q.delete();
    n_checks++; if (bus.in_count !== CNT_W'(0) || bus.out_count !== CNT_W'(0)) begin $display("FAIL rstmid_counts: got in=%0d out=%0d want 0 0", bus.in_count, bus.out_count); n_fail++; end
    n_checks++; if (bus.in_rd_valid !== 1'b0 || bus.out_rd_valid !== 1'b0 || bus.out_irq !== 1'b0) begin $display("FAIL rstmid_valid: got in=%b out=%b irq=%b want 0 0 0", bus.in_rd_valid, bus.out_rd_valid, bus.out_irq); n_fail++; end
    rst_n = 1'b1;
    step();
    n_checks++; if (bus.in_wr_ready !== 1'b1 || bus.out_wr_ready !== 1'b1) begin $display("FAIL rstmid_release: got in=%b out=%b want 1 1", bus.in_wr_ready, bus.out_wr_ready); n_fail++; end
    drive_out(32'hE5);
    exp_w = exp_out_q.pop_front();
    n_checks++; if (bus.out_rd_valid !== 1'b1 || bus.out_rd_data !== exp_w) begin $display("FAIL rstmid_after: got v=%b d=%h want v=1 d=%h", bus.out_rd_valid, bus.out_rd_data, exp_w); n_fail++; end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fill_drain();
    test_streaming();
    test_full_simul();
    test_irq();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
